// File: rtl/data_mem_arbiter.sv
// Two-port req/ack arbiter and access sequencer for the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
   parameter int DEPTH = 1025
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t      state, state_nxt;
   logic        cmd_we, cmd_port;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        any_req, grant, win;
   logic        in_range;
   logic [31:0] rdata_v;

   assign any_req  = req0 | req1;
   assign grant    = ((state == IDLE) || (state == RESP)) && any_req;
   assign in_range = (cmd_addr < DEPTH_W);

`ifdef DMEM_ARB_RR_EN
   logic last_grant;

   // On a tie the port not granted last wins; otherwise whichever port is requesting.
   assign win = (req0 & req1) ? ~last_grant : ~req0;

   always_ff @(posedge clk) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (grant)
         last_grant <= win;
   end
`else
   assign win = ~req0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = any_req ? ISSUE : IDLE;
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = any_req ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Fields are captured only at grant, so later input changes cannot disturb the access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_we    <= 1'b0;
         cmd_port  <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (grant) begin
         cmd_we    <= win ? we1    : we0;
         cmd_port  <= win;
         cmd_addr  <= win ? addr1  : addr0;
         cmd_wdata <= win ? wdata1 : wdata0;
      end
   end

   assign rdata_v = (~cmd_we & in_range) ? mem_rdata : '0;

   always_comb begin
      ack0      = 1'b0;
      ack1      = 1'b0;
      err0      = 1'b0;
      err1      = 1'b0;
      rdata0    = '0;
      rdata1    = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ISSUE: begin
            mem_write = cmd_we & in_range;
            mem_read  = ~cmd_we & in_range;
            mem_addr  = cmd_addr;
            mem_wdata = cmd_wdata;
         end
         RESP: begin
            ack0   = ~cmd_port;
            ack1   = cmd_port;
            err0   = ~cmd_port & ~in_range;
            err1   = cmd_port & ~in_range;
            rdata0 = cmd_port ? '0 : rdata_v;
            rdata1 = cmd_port ? rdata_v : '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural registered-read memory.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_write, mem_read;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:1024];

   always #5 clk = ~clk;

   // Registered-read memory: write and read both act on the rising edge.
   always @(posedge clk) begin
      if (mem_write && mem_addr < 32'd1025) mem[mem_addr[10:0]] <= mem_wdata;
      if (mem_read && mem_addr < 32'd1025)  mem_rdata <= mem[mem_addr[10:0]];
   end

   data_mem_arbiter #(.DEPTH(1025)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ack0"}, 32'(ack0), 32'd0);
      chk({tag, "_ack1"}, 32'(ack1), 32'd0);
      chk({tag, "_err"}, {30'd0, err1, err0}, 32'd0);
      chk({tag, "_memcmd"}, {30'd0, mem_read, mem_write}, 32'd0);
      chk({tag, "_maddr"}, mem_addr, 32'd0);
      chk({tag, "_mwdata"}, mem_wdata, 32'd0);
      chk({tag, "_rdata"}, rdata0 | rdata1, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      step(); step();
      chk_quiet("reset");
      rst_n = 1'b1;

      // Write port 0 addr 5, with addr changed after grant
      req0 = 1; we0 = 1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
      step();
      addr0 = 32'd9; wdata0 = 32'h0;
      chk("wr5_issue_we", 32'(mem_write), 32'd1);
      chk("wr5_issue_addr", mem_addr, 32'd5);
      chk("wr5_issue_data", mem_wdata, 32'hDEADBEEF);
      chk("wr5_issue_noack", 32'(ack0), 32'd0);
      step();
      chk("wr5_ack", 32'(ack0), 32'd1);
      chk("wr5_err", 32'(err0), 32'd0);
      chk("wr5_rdata", rdata0, 32'd0);
      req0 = 0;
      step();
      chk_quiet("idle1");

      // Read back addr 5
      req0 = 1; we0 = 0; addr0 = 32'd5;
      step();
      chk("rd5_issue_rd", 32'(mem_read), 32'd1);
      step();
      chk("rd5_ack", 32'(ack0), 32'd1);
      chk("rd5_rdata", rdata0, 32'hDEADBEEF);
      chk("rd5_err", 32'(err0), 32'd0);
      req0 = 0;
      step();

      // Port 1 held: write 1024, write 1025 (out of range), read 1024
      req1 = 1; we1 = 1; addr1 = 32'd1024; wdata1 = 32'hCAFE0400;
      step(); step();
      chk("wr1024_ack1", 32'(ack1), 32'd1);
      addr1 = 32'd1025; wdata1 = 32'h1;
      step();
      chk("oor_issue_cmd", {30'd0, mem_read, mem_write}, 32'd0);
      step();
      chk("oor_ack1", 32'(ack1), 32'd1);
      chk("oor_err1", 32'(err1), 32'd1);
      chk("oor_rdata1", rdata1, 32'd0);
      chk("oor_ack0", 32'(ack0), 32'd0);
      we1 = 0; addr1 = 32'd1024;
      step();
      chk("rd1024_issue_addr", mem_addr, 32'd1024);
      step();
      chk("rd1024_ack1", 32'(ack1), 32'd1);
      chk("rd1024_err1", 32'(err1), 32'd0);
      chk("rd1024_rdata1", rdata1, 32'hCAFE0400);
      req1 = 0;
      step();

      // Prepare words 3 and 4 back to back
      req0 = 1; we0 = 1; addr0 = 32'd3; wdata0 = 32'h33;
      step(); step();
      addr0 = 32'd4; wdata0 = 32'h44;
      step(); step();
      chk("wr4_ack", 32'(ack0), 32'd1);
      req0 = 0;
      step();

      // Held read: addr 3 then 4 in the ack cycle, no idle gap
      req0 = 1; we0 = 0; addr0 = 32'd3;
      step(); step();
      chk("rd3_ack", 32'(ack0), 32'd1);
      chk("rd3_rdata", rdata0, 32'h33);
      addr0 = 32'd4;
      step();
      chk("rd4_issue_rd", 32'(mem_read), 32'd1);
      chk("rd4_issue_addr", mem_addr, 32'd4);
      step();
      chk("rd4_ack", 32'(ack0), 32'd1);
      chk("rd4_rdata", rdata0, 32'h44);
      req0 = 0;
      step();

      // Both ports reading continuously; last grant was port 0
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'd3; addr1 = 32'd4;
      for (int k = 0; k < 4; k++) begin
         logic exp1;
`ifdef DMEM_ARB_RR_EN
         exp1 = (k % 2 == 0);
`else
         exp1 = 1'b0;
`endif
         step(); step();
         chk($sformatf("tie%0d_ack0", k), 32'(ack0), 32'(!exp1));
         chk($sformatf("tie%0d_ack1", k), 32'(ack1), 32'(exp1));
         chk($sformatf("tie%0d_rdata", k), exp1 ? rdata1 : rdata0, exp1 ? 32'h44 : 32'h33);
         if (k == 3) req0 = 0;
      end
      step(); step();
      chk("loser_ack1", 32'(ack1), 32'd1);
      chk("loser_rdata1", rdata1, 32'h44);
      req1 = 0;
      step();

      // Reset on the ISSUE edge of a write to addr 7
      req0 = 1; we0 = 1; addr0 = 32'd7; wdata0 = 32'hA5;
      step();
      chk("rst_issue_we", 32'(mem_write), 32'd1);
      rst_n = 1'b0; req0 = 0;
      step();
      chk_quiet("rst_mid");
      step();
      chk_quiet("rst_hold");
      rst_n = 1'b1;

      // First tie after reset goes to port 0 in both modes
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'd7; addr1 = 32'd3;
      step(); step();
      chk("post_rst_ack0", 32'(ack0), 32'd1);
      chk("post_rst_rdata7", rdata0, 32'hA5);
      req0 = 0;
      step(); step();
      chk("post_rst_ack1", 32'(ack1), 32'd1);
      chk("post_rst_rdata3", rdata1, 32'h33);
      req1 = 0;
      step();
      chk("final_idle_ack", {30'd0, ack1, ack0}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
